// File: rtl/interp_tap_scheduler.sv
// Tap sequencer for the quarter-pel affine interpolation MCM bank: steps samples through the
// shared tap multipliers, accumulates products, then rounds and saturates one output per block.
module interp_tap_scheduler #(
    parameter int unsigned TAPS   = 6,
    parameter int unsigned CENTER = 2,
    parameter int unsigned SHIFT  = 6,
    parameter int unsigned DW     = 16,
    parameter int unsigned OW     = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic [1:0]    s_frac,
    output logic [31:0]   mcm_x,
    output logic [3:0]    mcm_tap,
    output logic [1:0]    mcm_phase,
    input  logic [31:0]   mcm_y,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [OW-1:0] m_data
);

    localparam logic signed [32:0] RndOff = 33'sd1 <<< (SHIFT - 1);
    localparam logic signed [32:0] SatMax = (33'sd1 <<< (OW - 1)) - 33'sd1;
    localparam logic signed [32:0] SatMin = -(33'sd1 <<< (OW - 1));

    // StHold means a result is registered and not yet consumed; input stalls only while
    // m_ready is also low, so a consume and the next tap 0 can share a cycle.
    typedef enum logic [0:0] {StAcc, StHold} state_e;

    state_e             state_q, state_d;
    logic [3:0]         tap_cnt_q, tap_cnt_d;
    logic [1:0]         phase_q, phase_d;
    logic signed [31:0] acc_q, acc_d;
    logic [OW-1:0]      m_data_q, m_data_d;

    logic               accept, first, last;
    logic [1:0]         phase_eff;
    logic signed [31:0] x_ext, prod, sum;
    logic signed [32:0] rnd, rsh;
    logic [OW-1:0]      sat;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StAcc;
            tap_cnt_q <= '0;
            phase_q   <= '0;
            acc_q     <= '0;
            m_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            tap_cnt_q <= tap_cnt_d;
            phase_q   <= phase_d;
            acc_q     <= acc_d;
            m_data_q  <= m_data_d;
        end
    end

    // Datapath: effective phase, product selection, final sum, round and saturate.
    always_comb begin
        x_ext     = {{(32 - DW){s_data[DW-1]}}, s_data};
        first     = (tap_cnt_q == '0);
        last      = (tap_cnt_q == 4'(TAPS - 1));
        phase_eff = first ? s_frac : phase_q;
        prod      = '0;
        if (phase_eff != 2'd0) begin
            prod = $signed(mcm_y);
        end else if (tap_cnt_q == 4'(CENTER)) begin
            prod = x_ext <<< SHIFT;
        end
        sum = (first ? 32'sd0 : acc_q) + prod;
        rnd = $signed({sum[31], sum}) + RndOff;
        rsh = rnd >>> SHIFT;
        if (rsh > SatMax) begin
            sat = SatMax[OW-1:0];
        end else if (rsh < SatMin) begin
            sat = SatMin[OW-1:0];
        end else begin
            sat = rsh[OW-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        tap_cnt_d = tap_cnt_q;
        phase_d   = phase_q;
        acc_d     = acc_q;
        m_data_d  = m_data_q;
        if (state_q == StHold && m_ready) begin
            state_d = StAcc;
        end
        if (accept) begin
            tap_cnt_d = last ? 4'd0 : tap_cnt_q + 4'd1;
            acc_d     = sum;
            if (first) begin
                phase_d = s_frac;
            end
            if (last) begin
                state_d  = StHold;
                m_data_d = sat;
            end
        end
    end

    always_comb begin
        s_ready   = (state_q == StAcc) || m_ready;
        accept    = s_valid && s_ready;
        m_valid   = (state_q == StHold);
        m_data    = m_data_q;
        mcm_x     = x_ext;
        mcm_tap   = tap_cnt_q;
        mcm_phase = phase_eff;
    end

endmodule

// File: tb/tb_interp_tap_scheduler.sv
// Self-checking bench for interp_tap_scheduler: directed vector table, hand sequences for reset
// and backpressure, and a randomized stream scored against a block-level arithmetic model.
module tb_interp_tap_scheduler;

    localparam int NTAPS = 6;
    localparam int CTR   = 2;
    localparam int NB    = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_ready, m_valid, m_ready;
    logic [15:0] s_data, m_data;
    logic [1:0]  s_frac, mcm_phase;
    logic [31:0] mcm_x, mcm_y;
    logic [3:0]  mcm_tap;

    int checks = 0;
    int failures = 0;

    logic             ovr_en = 1'b0;
    logic [5:0][31:0] ovr_cur = '0;

    typedef struct packed {
        logic [1:0]       frac;
        logic [5:0][15:0] smp;
        logic             ovr_en;
        logic [5:0][31:0] ovr;
        logic [15:0]      expv;
    } vec_t;

    vec_t vecs [7];
    int   exp_q [$];

    always #5 clk = ~clk;

    interp_tap_scheduler #(
        .TAPS(NTAPS), .CENTER(CTR), .SHIFT(6), .DW(16), .OW(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_frac(s_frac), .mcm_x(mcm_x), .mcm_tap(mcm_tap), .mcm_phase(mcm_phase),
        .mcm_y(mcm_y), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
    );

    function automatic int coef(input int ph, input int tp);
        int c [3][6];
        c = '{'{-1, 4, -10, 58, 17, -4}, '{1, -5, 36, 36, -5, 1}, '{-4, 17, 58, -10, 4, -1}};
        if (ph < 1 || ph > 3 || tp < 0 || tp > 5) return 0;
        return c[ph-1][tp];
    endfunction

    // External MCM mux: garbage on full-pel so the DUT must not use it there.
    always_comb begin
        mcm_y = 32'hDEAD_BEEF;
        if (mcm_tap < 4'd6) begin
            if (ovr_en) mcm_y = ovr_cur[mcm_tap];
            else if (mcm_phase != 2'd0)
                mcm_y = 32'($signed(mcm_x) * coef(int'(mcm_phase), int'(mcm_tap)));
        end
    end

    // Block-level reference: weighted sum, round half up, clamp to 16 bits.
    function automatic int model(input int frac, input int smp [6]);
        int     s = 0;
        longint r;
        for (int t = 0; t < NTAPS; t++) begin
            if (frac != 0) s += smp[t] * coef(frac, t);
            else if (t == CTR) s += smp[t] * 64;
        end
        r = (longint'(s) + 32) >>> 6;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return int'(r);
    endfunction

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic run_block(input int frac, input logic [5:0][15:0] smp, input int expv,
                             input string name);
        for (int t = 0; t < NTAPS; t++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_data  = smp[t];
            s_frac  = (t == 0) ? 2'(frac) : 2'(3 - frac);
            #1;
            chk({name, " s_ready"}, s_ready, 1);
            chk({name, " mcm_tap"}, mcm_tap, t);
            chk({name, " mcm_phase"}, mcm_phase, frac);
            chk({name, " mcm_x"}, $signed(mcm_x), $signed(smp[t]));
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        chk({name, " m_valid"}, m_valid, 1);
        chk({name, " m_data"}, $signed(m_data), expv);
    endtask

    task automatic drain();
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{frac: 2'd2, smp: {6{16'd100}}, ovr_en: 1'b0, ovr: '0, expv: 16'd100};
        vecs[1] = '{frac: 2'd0, smp: {16'd60, 16'd50, 16'd40, 16'd30, 16'd20, 16'd10},
                    ovr_en: 1'b0, ovr: '0, expv: 16'd30};
        vecs[2] = '{frac: 2'd1, smp: {6{16'd7}}, ovr_en: 1'b1, ovr: {160'd0, 32'hFFFF_FFDF},
                    expv: 16'hFFFF};
        vecs[3] = '{frac: 2'd1, smp: {6{16'd7}}, ovr_en: 1'b1, ovr: {160'd0, 32'd31},
                    expv: 16'd0};
        vecs[4] = '{frac: 2'd1, smp: {6{16'd7}}, ovr_en: 1'b1, ovr: {160'd0, 32'd32},
                    expv: 16'd1};
        vecs[5] = '{frac: 2'd3, smp: {6{16'd9}}, ovr_en: 1'b1, ovr: {160'd0, 32'h7FFF_0000},
                    expv: 16'h7FFF};
        vecs[6] = '{frac: 2'd3, smp: {6{16'd9}}, ovr_en: 1'b1, ovr: {160'd0, 32'hFF00_0000},
                    expv: 16'h8000};

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_frac = '0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset m_valid", m_valid, 0);
        chk("reset m_data", m_data, 0);
        chk("reset s_ready", s_ready, 1);
        chk("reset mcm_tap", mcm_tap, 0);

        for (int i = 0; i < 7; i++) begin
            ovr_en  = vecs[i].ovr_en;
            ovr_cur = vecs[i].ovr;
            run_block(int'(vecs[i].frac), vecs[i].smp, int'($signed(vecs[i].expv)),
                      $sformatf("vec%0d", i));
        end
        ovr_en = 1'b0;

        // Reset mid-block after three taps: partial sum must be discarded.
        drain();
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = 16'd500; s_frac = 2'd2;
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midreset m_valid", m_valid, 0);
        chk("midreset m_data", m_data, 0);
        chk("midreset mcm_tap", mcm_tap, 0);
        chk("midreset s_ready", s_ready, 1);
        run_block(2, {6{16'd100}}, 100, "post_reset");

        // Backpressure: block 1 result held 4 cycles while block 2 tap 0 waits.
        drain();
        m_ready = 1'b0;
        for (int t = 0; t < NTAPS; t++) begin
            @(negedge clk);
            s_valid = 1'b1; s_data = 16'd100; s_frac = (t == 0) ? 2'd2 : 2'd0;
            @(posedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            s_data = 16'd1000; s_frac = 2'd1;
            #1;
            chk("hold s_ready", s_ready, 0);
            chk("hold m_valid", m_valid, 1);
            chk("hold m_data", $signed(m_data), 100);
            chk("hold mcm_tap", mcm_tap, 0);
            @(posedge clk);
        end
        @(negedge clk);
        m_ready = 1'b1;
        #1;
        chk("release s_ready", s_ready, 1);
        chk("release mcm_phase", mcm_phase, 1);
        @(posedge clk);
        for (int t = 1; t < NTAPS; t++) begin
            @(negedge clk);
            s_frac = 2'd3;
            #1;
            if (t == 1) chk("consumed m_valid", m_valid, 0);
            chk("blk2 mcm_tap", mcm_tap, t);
            chk("blk2 mcm_phase", mcm_phase, 1);
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        #1;
        chk("blk2 m_valid", m_valid, 1);
        chk("blk2 m_data", $signed(m_data), 1000);
        drain();

        // Randomized stream with input gaps and random backpressure.
        fork
            begin : driver
                int smp [6];
                int bfrac = 0;
                for (int b = 0; b < NB; b++) begin
                    for (int t = 0; t < NTAPS; ) begin
                        @(negedge clk);
                        s_valid = ($urandom_range(0, 3) != 0);
                        s_data  = 16'($urandom);
                        s_frac  = 2'($urandom);
                        #2;
                        if (s_valid && s_ready) begin
                            if (t == 0) bfrac = int'(s_frac);
                            smp[t] = int'($signed(s_data));
                            t++;
                            if (t == NTAPS) exp_q.push_back(model(bfrac, smp));
                        end
                    end
                end
                @(negedge clk);
                s_valid = 1'b0;
            end
            begin : consumer
                int          got = 0;
                logic        held = 1'b0;
                logic [15:0] held_val = '0;
                while (got < NB) begin
                    @(negedge clk);
                    m_ready = ($urandom_range(0, 2) != 0);
                    #2;
                    if (held) chk("rand stable m_data", m_data, held_val);
                    if (m_valid && !m_ready) chk("rand hold s_ready", s_ready, 0);
                    held     = m_valid && !m_ready;
                    held_val = m_data;
                    if (m_valid && m_ready) begin
                        if (exp_q.size() == 0) begin
                            chk("rand unexpected output", 1, 0);
                        end else begin
                            chk($sformatf("rand out%0d", got), $signed(m_data), exp_q.pop_front());
                        end
                        got++;
                    end
                end
            end
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interp_tap_scheduler.md
# interp_tap_scheduler

Sequencing controller for the quarter-precision affine-interpolation MCM bank. It accepts a stream of reference samples, one per tap, and drives each sample into the shared per-tap multiplier blocks, selecting tap and fractional phase. It accumulates the returned products, then rounds and saturates the sum, emitting one filtered sample per TAPS inputs over a valid/ready handshake. It sits between the reference-sample fetch and the affine prediction writeback.

## Interface
- TAPS, 6: filter taps per output sample (2..16).
- CENTER, 2: tap index carrying the full-pel sample when frac = 0.
- SHIFT, 6: normalisation shift; coefficients of every phase sum to 2^SHIFT.
- DW, 16: signed input sample width.
- OW, 16: signed output width (saturated).
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample accepted when s_valid & s_ready.
- s_data  in  DW  signed sample.
- s_frac  in  2  phase (0 = full-pel, 1..3 = 1/4, 2/4, 3/4); sampled only on tap 0.
- mcm_x  out  32  s_data sign-extended; drives X of all tap MCM blocks.
- mcm_tap  out  4  current tap index, selects the MCM block.
- mcm_phase  out  2  latched/current phase, selects Y1/Y2/Y3 (phase-1).
- mcm_y  in  32  signed product returned combinationally by the external MCM mux, same cycle.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumed when m_valid & m_ready.
- m_data  out  OW  rounded, saturated result.

## Operation
- Registers: tap_cnt (0..TAPS-1), phase (2b), acc (32b signed), m_valid, m_data.
- States: ACC (collecting taps), HOLD (result pending, stalled).
- ACC: s_ready = 1. On an accepted sample:
  - phase_eff = s_frac if tap_cnt = 0, else latched phase.
  - On tap 0, latch s_frac into phase.
  - prod = mcm_y if phase_eff ≠ 0. Otherwise prod = sext(s_data) << SHIFT when tap_cnt = CENTER, else 0.
  - acc ← prod on tap 0, else acc + prod.
  - tap_cnt increments; on TAPS-1 it wraps to 0.
- Last tap accepted: the final sum S = acc + prod is rounded to R = (S + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift).
  - R is saturated to [-2^(OW-1), 2^(OW-1)-1] and registered into m_data; m_valid ← 1.
- While m_valid = 1 and m_ready = 0: state HOLD, s_ready = 0, m_data held stable.
- m_valid = 1 and m_ready = 1 in ACC: the next block's tap 0 may be accepted in the same cycle.
- Simultaneous consume and new last tap: m_valid stays 1 with the new m_data.
- mcm_x, mcm_tap and mcm_phase are combinational from s_data, tap_cnt and phase_eff. They are valid whenever s_valid = 1.
- acc wraps modulo 2^32; no internal overflow detection. Saturation applies at the output only.
- s_frac on taps 1..TAPS-1 is ignored.

## Timing
- Reset (rst_n = 0 at a clk edge): tap_cnt = 0, phase = 0, acc = 0, m_valid = 0, m_data = 0, state ACC.
  - s_ready = 1 from the first cycle after reset release.
  - A partially accumulated block is discarded on reset.
- Latency: m_valid rises on the clock edge that accepts the last tap. Visible 1 cycle after the last-tap handshake.
- Throughput: one output per TAPS cycles with continuous s_valid and m_ready = 1; no bubbles between blocks.
- Stall: s_ready deasserts only in HOLD. tap_cnt never advances without an s handshake.
- Input gaps (s_valid = 0 mid-block) leave all state unchanged.

## Test plan
- Reset: drive rst_n = 0 mid-block (tap_cnt = 3). Next cycle: m_valid = 0, m_data = 0, tap_cnt = 0, s_ready = 1.
- Flat field: frac = 2, six samples of 100, bench MCM coefficients summing to 64. Response: m_data = 100, m_valid one cycle after the 6th handshake, mcm_tap sequence 0..5, mcm_phase = 2 throughout.
- Full-pel: frac = 0, samples 10, 20, 30, 40, 50, 60 with mcm_y forced to garbage. Response: m_data = 30.
- Rounding: frac = 1, products chosen so S = -33. Response: m_data = -1. With S = 31, m_data = 0; with S = 32, m_data = 1.
- Saturation: frac = 3, S = 0x7FFF_0000. Response: m_data = 32767. With S = -0x0100_0000, m_data = -32768.
- Backpressure and back-to-back:
  - Two blocks streamed continuously with m_ready = 0 for 4 cycles after the first result. Response: s_ready = 0 during HOLD and m_data stable.
  - When m_ready rises, tap 0 of block 2 is accepted in the same cycle.
  - Block 2 s_frac change on a non-zero tap is ignored.
